// File: rtl/adder_result_checker_if.sv
// Bundles the checker's stimulus/result inputs and status outputs into one port.
// sig_o exists only when CHK_SIGNATURE_EN is defined.
interface adder_result_checker_if;
  logic        start_i;
  logic        op_valid_i;
  logic [7:0]  a_i;
  logic [7:0]  b_i;
  logic        res_valid_i;
  logic [7:0]  res_i;
  logic        busy_o;
  logic        done_o;
  logic        pass_o;
  logic [31:0] res_cnt_o;
  logic [31:0] err_cnt_o;
  logic [31:0] first_err_idx_o;
  logic [7:0]  first_err_exp_o;
  logic [7:0]  first_err_got_o;
  logic        ovf_o;
  logic        unf_o;
`ifdef CHK_SIGNATURE_EN
  logic [31:0] sig_o;
`endif

  modport master (
    output start_i, op_valid_i, a_i, b_i, res_valid_i, res_i,
    input  busy_o, done_o, pass_o, res_cnt_o, err_cnt_o, first_err_idx_o,
           first_err_exp_o, first_err_got_o, ovf_o, unf_o
`ifdef CHK_SIGNATURE_EN
    , input sig_o
`endif
  );

  modport slave (
    input  start_i, op_valid_i, a_i, b_i, res_valid_i, res_i,
    output busy_o, done_o, pass_o, res_cnt_o, err_cnt_o, first_err_idx_o,
           first_err_exp_o, first_err_got_o, ovf_o, unf_o
`ifdef CHK_SIGNATURE_EN
    , output sig_o
`endif
  );
endinterface

// File: rtl/adder_result_checker.sv
// Checks an 8-bit adder's results against a FIFO of expected sums over a run of EXP_COUNT results.
// Defining CHK_SIGNATURE_EN adds a rotate/XOR signature of all accepted results on sig_o.
module adder_result_checker #(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned EXP_COUNT = 2000000
) (
  input logic                   clk_i,
  input logic                   reset_i,
  adder_result_checker_if.slave chk
);
  localparam int unsigned PtrW   = $clog2(DEPTH);
  localparam int unsigned CntW   = $clog2(DEPTH + 1);
  localparam logic [31:0] CntMax = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e          state_q, state_d;
  logic [7:0]      fifoMem_q [DEPTH];
  logic [PtrW-1:0] wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [31:0]     resCnt_q, resCnt_d, errCnt_q, errCnt_d, firstIdx_q, firstIdx_d;
  logic [7:0]      firstExp_q, firstExp_d, firstGot_q, firstGot_d;
  logic            ovf_q, ovf_d, unf_q, unf_d, pass_q, pass_d;
`ifdef CHK_SIGNATURE_EN
  logic [31:0]     sig_q, sig_d;
`endif

  logic       inRun, launch, accept, push, fifoEmpty, fifoFull;
  logic       bypass, popFifo, writeFifo, underflow, mismatch;
  logic [7:0] sum, expected;

  assign inRun     = (state_q == RUN);
  assign launch    = !inRun && chk.start_i;
  assign accept    = inRun && chk.res_valid_i;
  assign push      = inRun && chk.op_valid_i;
  assign fifoEmpty = (count_q == '0);
  assign fifoFull  = (count_q == CntW'(DEPTH));
  assign sum       = chk.a_i + chk.b_i;

  // A result arriving with an empty FIFO is checked against the operand pair of the same cycle.
  assign bypass    = accept && push && fifoEmpty;
  assign popFifo   = accept && !fifoEmpty;
  assign underflow = accept && !push && fifoEmpty;
  assign writeFifo = push && !bypass && (!fifoFull || popFifo);

  always_comb begin
    expected = 8'h00;
    if (bypass) begin
      expected = sum;
    end else if (popFifo) begin
      expected = fifoMem_q[rdPtr_q];
    end
  end

  assign mismatch = accept && (underflow || (chk.res_i != expected));

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: if (chk.start_i) state_d = RUN;
      RUN:        if (accept && (resCnt_d == 32'(EXP_COUNT))) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    wrPtr_d    = wrPtr_q;
    rdPtr_d    = rdPtr_q;
    count_d    = count_q;
    resCnt_d   = resCnt_q;
    errCnt_d   = errCnt_q;
    firstIdx_d = firstIdx_q;
    firstExp_d = firstExp_q;
    firstGot_d = firstGot_q;
    ovf_d      = ovf_q;
    unf_d      = unf_q;
`ifdef CHK_SIGNATURE_EN
    sig_d      = sig_q;
`endif
    if (launch) begin
      wrPtr_d    = '0;
      rdPtr_d    = '0;
      count_d    = '0;
      resCnt_d   = '0;
      errCnt_d   = '0;
      firstIdx_d = '0;
      firstExp_d = '0;
      firstGot_d = '0;
      ovf_d      = 1'b0;
      unf_d      = 1'b0;
`ifdef CHK_SIGNATURE_EN
      sig_d      = '0;
`endif
    end else begin
      if (writeFifo) wrPtr_d = wrPtr_q + PtrW'(1);
      if (popFifo)   rdPtr_d = rdPtr_q + PtrW'(1);
      if (writeFifo && !popFifo) begin
        count_d = count_q + CntW'(1);
      end else if (popFifo && !writeFifo) begin
        count_d = count_q - CntW'(1);
      end
      if (push && !bypass && fifoFull && !popFifo) ovf_d = 1'b1;
      if (underflow) unf_d = 1'b1;
      if (accept && (resCnt_q != CntMax)) resCnt_d = resCnt_q + 32'd1;
      if (mismatch && (errCnt_q != CntMax)) errCnt_d = errCnt_q + 32'd1;
      // An error count of zero means no mismatch has been captured yet in this run.
      if (mismatch && (errCnt_q == '0)) begin
        firstIdx_d = resCnt_q;
        firstExp_d = expected;
        firstGot_d = chk.res_i;
      end
`ifdef CHK_SIGNATURE_EN
      if (accept) sig_d = {sig_q[30:0], sig_q[31]} ^ {24'h0, chk.res_i};
`endif
    end
    pass_d = (state_d == DONE) && (errCnt_d == '0) && !ovf_d && !unf_d;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      resCnt_q   <= '0;
      errCnt_q   <= '0;
      firstIdx_q <= '0;
      firstExp_q <= '0;
      firstGot_q <= '0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      pass_q     <= 1'b0;
`ifdef CHK_SIGNATURE_EN
      sig_q      <= '0;
`endif
    end else begin
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      count_q    <= count_d;
      resCnt_q   <= resCnt_d;
      errCnt_q   <= errCnt_d;
      firstIdx_q <= firstIdx_d;
      firstExp_q <= firstExp_d;
      firstGot_q <= firstGot_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
      pass_q     <= pass_d;
`ifdef CHK_SIGNATURE_EN
      sig_q      <= sig_d;
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i && writeFifo) begin
      fifoMem_q[wrPtr_q] <= sum;
    end
  end

  assign chk.busy_o          = (state_q == RUN);
  assign chk.done_o          = (state_q == DONE);
  assign chk.pass_o          = pass_q;
  assign chk.res_cnt_o       = resCnt_q;
  assign chk.err_cnt_o       = errCnt_q;
  assign chk.first_err_idx_o = firstIdx_q;
  assign chk.first_err_exp_o = firstExp_q;
  assign chk.first_err_got_o = firstGot_q;
  assign chk.ovf_o           = ovf_q;
  assign chk.unf_o           = unf_q;
`ifdef CHK_SIGNATURE_EN
  assign chk.sig_o           = sig_q;
`endif
endmodule

// File: tb/tb_adder_result_checker.sv
// Bench for adder_result_checker: directed scenarios plus randomized runs against a queue-based model.
// Signature checks are included when CHK_SIGNATURE_EN is defined.
module tb_adder_result_checker;
  localparam int DEPTH = 8;
  localparam int EXP   = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  adder_result_checker_if bus ();

  adder_result_checker #(.DEPTH(DEPTH), .EXP_COUNT(EXP)) dut (
    .clk_i  (clk),
    .reset_i(reset),
    .chk    (bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  bit checkEn     = 1'b0;

  // Reference model: state as a small integer, expected sums in a queue.
  int          mState;
  logic [7:0]  mq[$];
  int unsigned mCnt, mErr, mIdx;
  logic [7:0]  mExp, mGot;
  bit          mOvf, mUnf;
`ifdef CHK_SIGNATURE_EN
  int unsigned mSig;
`endif

  logic [7:0] opA [EXP];
  logic [7:0] opB [EXP];
  logic [7:0] resV[EXP];

  task automatic modelClear();
    mq.delete();
    mCnt = 0; mErr = 0; mIdx = 0; mExp = 0; mGot = 0; mOvf = 0; mUnf = 0;
`ifdef CHK_SIGNATURE_EN
    mSig = 0;
`endif
  endtask

  always @(posedge clk) begin
    logic [7:0] e;
    bit         und, byp, miss;
    if (reset) begin
      modelClear();
      mState = 0;
    end else if (mState != 1) begin
      if (bus.start_i) begin
        modelClear();
        mState = 1;
      end
    end else begin
      byp = bus.op_valid_i && bus.res_valid_i && (mq.size() == 0);
      und = 0;
      e   = 8'h00;
      if (bus.res_valid_i) begin
        if (byp) e = 8'((int'(bus.a_i) + int'(bus.b_i)) % 256);
        else if (mq.size() == 0) und = 1;
        else e = mq.pop_front();
      end
      if (bus.op_valid_i && !byp) begin
        if (mq.size() < DEPTH) mq.push_back(8'((int'(bus.a_i) + int'(bus.b_i)) % 256));
        else mOvf = 1;
      end
      if (bus.res_valid_i) begin
        miss = und || (bus.res_i != e);
        if (und) mUnf = 1;
        if (miss && mErr == 0) begin
          mIdx = mCnt; mExp = e; mGot = bus.res_i;
        end
        if (miss && mErr != 32'hFFFF_FFFF) mErr++;
        if (mCnt != 32'hFFFF_FFFF) mCnt++;
`ifdef CHK_SIGNATURE_EN
        mSig = ((mSig << 1) | (mSig >> 31)) ^ 32'(bus.res_i);
`endif
        if (mCnt == EXP) mState = 2;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every cycle after reset the registered outputs must match the model.
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("busy",    32'(bus.busy_o), 32'(mState == 1));
      checkOutput("done",    32'(bus.done_o), 32'(mState == 2));
      checkOutput("pass",    32'(bus.pass_o), 32'(mState == 2 && mErr == 0 && !mOvf && !mUnf));
      checkOutput("res_cnt", bus.res_cnt_o, mCnt);
      checkOutput("err_cnt", bus.err_cnt_o, mErr);
      checkOutput("fe_idx",  bus.first_err_idx_o, mIdx);
      checkOutput("fe_exp",  32'(bus.first_err_exp_o), 32'(mExp));
      checkOutput("fe_got",  32'(bus.first_err_got_o), 32'(mGot));
      checkOutput("ovf",     32'(bus.ovf_o), 32'(mOvf));
      checkOutput("unf",     32'(bus.unf_o), 32'(mUnf));
`ifdef CHK_SIGNATURE_EN
      checkOutput("sig",     bus.sig_o, mSig);
`endif
    end
  end

  task automatic applyStimulus(input logic rst, input logic st, input logic ov,
                               input logic [7:0] a, input logic [7:0] b,
                               input logic rv, input logic [7:0] r);
    @(negedge clk);
    reset           = rst;
    bus.start_i     = st;
    bus.op_valid_i  = ov;
    bus.a_i         = a;
    bus.b_i         = b;
    bus.res_valid_i = rv;
    bus.res_i       = r;
  endtask

  task automatic idleCycle();
    applyStimulus(0, 0, 0, 8'h00, 8'h00, 0, 8'h00);
  endtask

  // Start a run, then issue EXP operand pairs with results returning two cycles later.
  task automatic runStream();
    int ri;
    applyStimulus(0, 1, 0, 8'h00, 8'h00, 0, 8'h00);
    for (int i = 0; i < EXP + 2; i++) begin
      ri = (i >= 2) ? i - 2 : 0;
      applyStimulus(0, 0, i < EXP, opA[(i < EXP) ? i : 0], opB[(i < EXP) ? i : 0],
                    i >= 2, resV[ri]);
    end
    idleCycle();
  endtask

  initial begin
    int pOp, pRes, seen;
    logic [7:0] a, b, r;
    logic ov, rv;

    reset = 1'b1;
    bus.start_i = 0; bus.op_valid_i = 0; bus.a_i = 0; bus.b_i = 0;
    bus.res_valid_i = 0; bus.res_i = 0;
    @(negedge clk);
    checkEn = 1'b1;
    idleCycle();
    checkOutput("rst_busy",    32'(bus.busy_o), 32'd0);
    checkOutput("rst_res_cnt", bus.res_cnt_o, 32'd0);
    checkOutput("rst_pass",    32'(bus.pass_o), 32'd0);

    opA = '{8'd3, 8'd255, 8'd10, 8'd0, 8'd100, 8'd200, 8'd1, 8'd128};
    opB = '{8'd4, 8'd1,   8'd20, 8'd0, 8'd100, 8'd100, 8'd1, 8'd128};
    resV = '{8'd7, 8'd0,  8'd30, 8'd0, 8'd200, 8'd44,  8'd2, 8'd0};

    runStream();
    checkOutput("clean_done",    32'(bus.done_o), 32'd1);
    checkOutput("clean_pass",    32'(bus.pass_o), 32'd1);
    checkOutput("clean_res_cnt", bus.res_cnt_o, 32'd8);
    checkOutput("clean_err_cnt", bus.err_cnt_o, 32'd0);
    checkOutput("model_cnt",     mCnt, 32'd8);

    resV[2] = 8'd31;
    runStream();
    checkOutput("err_cnt1",  bus.err_cnt_o, 32'd1);
    checkOutput("err_idx",   bus.first_err_idx_o, 32'd2);
    checkOutput("err_exp",   32'(bus.first_err_exp_o), 32'd30);
    checkOutput("err_got",   32'(bus.first_err_got_o), 32'd31);
    checkOutput("err_pass",  32'(bus.pass_o), 32'd0);
    checkOutput("model_idx", mIdx, 32'd2);
    resV[2] = 8'd30;

    applyStimulus(0, 1, 0, 8'h00, 8'h00, 0, 8'h00);
    for (int i = 0; i < DEPTH + 1; i++) applyStimulus(0, 0, 1, 8'(i), 8'(2 * i), 0, 8'h00);
    idleCycle();
    checkOutput("ovf_set",  32'(bus.ovf_o), 32'd1);
    checkOutput("ovf_busy", 32'(bus.busy_o), 32'd1);
    for (int i = 0; i < DEPTH; i++) applyStimulus(0, 0, 0, 8'h00, 8'h00, 1, 8'(3 * i));
    idleCycle();
    checkOutput("ovf_done", 32'(bus.done_o), 32'd1);
    checkOutput("ovf_err",  bus.err_cnt_o, 32'd0);
    checkOutput("ovf_pass", 32'(bus.pass_o), 32'd0);

    applyStimulus(0, 1, 0, 8'h00, 8'h00, 0, 8'h00);
    applyStimulus(0, 0, 0, 8'h00, 8'h00, 1, 8'h33);
    idleCycle();
    checkOutput("unf_set",  32'(bus.unf_o), 32'd1);
    checkOutput("unf_err",  bus.err_cnt_o, 32'd1);
    checkOutput("unf_exp",  32'(bus.first_err_exp_o), 32'd0);
    checkOutput("unf_got",  32'(bus.first_err_got_o), 32'h33);
    applyStimulus(0, 0, 1, 8'd5, 8'd6, 1, 8'd11);
    idleCycle();
    checkOutput("byp_err",  bus.err_cnt_o, 32'd1);
    checkOutput("byp_cnt",  bus.res_cnt_o, 32'd2);
    for (int i = 0; i < EXP - 2; i++) applyStimulus(0, 0, 1, 8'(i), 8'(i), 1, 8'(2 * i));
    idleCycle();
    checkOutput("unf_done", 32'(bus.done_o), 32'd1);
    checkOutput("unf_pass", 32'(bus.pass_o), 32'd0);

    applyStimulus(0, 1, 0, 8'h00, 8'h00, 0, 8'h00);
    applyStimulus(0, 0, 1, 8'd1, 8'd2, 1, 8'd3);
    applyStimulus(0, 0, 1, 8'd4, 8'd5, 1, 8'd9);
    applyStimulus(1, 1, 1, 8'd7, 8'd7, 1, 8'd99);
    idleCycle();
    checkOutput("mrst_busy", 32'(bus.busy_o), 32'd0);
    checkOutput("mrst_done", 32'(bus.done_o), 32'd0);
    checkOutput("mrst_cnt",  bus.res_cnt_o, 32'd0);
    checkOutput("mrst_err",  bus.err_cnt_o, 32'd0);
    runStream();
    checkOutput("mrst_pass", 32'(bus.pass_o), 32'd1);

`ifdef CHK_SIGNATURE_EN
    applyStimulus(0, 1, 0, 8'h00, 8'h00, 0, 8'h00);
    applyStimulus(0, 0, 1, 8'd0, 8'd1, 1, 8'h01);
    idleCycle();
    checkOutput("sig_first", bus.sig_o, 32'h0000_0001);
    applyStimulus(0, 0, 1, 8'd1, 8'd1, 1, 8'h02);
    idleCycle();
    checkOutput("sig_second", bus.sig_o, 32'h0000_0000);
`endif

    for (int run = 0; run < 16; run++) begin
      if (mState == 1) applyStimulus(1, 0, 0, 8'h00, 8'h00, 0, 8'h00);
      applyStimulus(0, 1, 0, 8'h00, 8'h00, 0, 8'h00);
      pOp  = $urandom_range(20, 90);
      pRes = $urandom_range(20, 90);
      seen = 0;
      for (int c = 0; c < 150 && seen < 3; c++) begin
        ov = ($urandom_range(0, 99) < pOp);
        rv = ($urandom_range(0, 99) < pRes);
        a  = 8'($urandom);
        b  = 8'($urandom);
        if (mq.size() > 0) r = mq[0];
        else if (ov) r = a + b;
        else r = 8'($urandom);
        if ($urandom_range(0, 9) == 0) r = 8'($urandom);
        if ($urandom_range(0, 79) == 0) applyStimulus(1, 0, ov, a, b, rv, r);
        else applyStimulus(0, $urandom_range(0, 29) == 0, ov, a, b, rv, r);
        if (mState == 2) seen++;
      end
    end
    idleCycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
